// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port data memory; byte-enabled
// stores are done as read-modify-write, read data is returned registered.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES  = 256,
  parameter bit          RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester holds req and its command stable until it sees gnt
  // (a one-cycle pulse in the ACCESS cycle); rvalid pulses once, one cycle
  // after gnt, only for reads, and rdata holds until that port's next read.
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_port;
  logic        r_we;
  logic        r_oor;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_gnt;
  logic [1:0]  r_rvalid;
  logic [1:0]  r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic        r_mem_we;

  logic        w_any;
  logic        w_win;
  logic        w_we;
  logic        w_oor;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_merged;

  // Under contention the port that did not win last time gets the memory.
  assign w_any   = m0_req | m1_req;
  assign w_win   = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_we    = w_win ? m1_we    : m0_we;
  assign w_addr  = w_win ? m1_addr  : m0_addr;
  assign w_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_be    = w_win ? m1_be    : m0_be;
  assign w_oor   = (w_addr > ADDR_MAX);

  // be[i] selects byte lane i; lane 3 is the lowest address (big-endian).
  always_comb begin
    w_merged = mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= RESET_LAST;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_oor    <= 1'b0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      r_mem_we <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state        <= ACCESS;
            r_last         <= w_win;
            r_port         <= w_win;
            r_we           <= w_we;
            r_oor          <= w_oor;
            r_wdata        <= w_wdata;
            r_be           <= w_be;
            r_mem_a        <= w_addr;
            r_gnt[w_win]   <= 1'b1;
            r_err[w_win]   <= w_oor;
            if (w_we && !w_oor && (w_be == 4'hF)) begin
              r_mem_we <= 1'b1;
              r_mem_wd <= w_wdata;
            end
          end
        end
        ACCESS: begin
          r_state <= IDLE;
          if (!r_we) begin
            r_rvalid[r_port] <= 1'b1;
            if (r_port) r_rdata1 <= r_oor ? 32'h0 : mem_rd;
            else        r_rdata0 <= r_oor ? 32'h0 : mem_rd;
          end else if (!r_oor && (r_be != 4'h0) && (r_be != 4'hF)) begin
            r_state  <= RMW_WR;
            r_mem_wd <= w_merged;
            r_mem_we <= 1'b1;
          end
        end
        RMW_WR: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_gnt      = r_gnt[0];
  assign m1_gnt      = r_gnt[1];
  assign m0_rvalid   = r_rvalid[0];
  assign m1_rvalid   = r_rvalid[1];
  assign m0_err      = r_err[0];
  assign m1_err      = r_err[1];
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign mem_a       = r_mem_a;
  assign mem_wd      = r_mem_wd;
  assign mem_we      = r_mem_we;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, transaction-timeline reference
// model compared every cycle, plus directed scenarios with literal results.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [1:0]  dbg_state;

  logic [7:0]  bmem    [256];
  logic [7:0]  ref_mem [256];
  logic        pl_req = 1'b0;
  logic [31:0] pl_addr = '0, pl_data = '0;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.MEM_BYTES(256), .RESET_LAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100us");
    $fatal(1);
  end

  // ---------------- memory (combinational read, posedge write) ----------------
  always_comb begin
    mem_rd = '0;
    for (int k = 0; k < 4; k++)
      if (mem_a + 32'(k) < 32'd256) mem_rd[31-8*k -: 8] = bmem[8'(mem_a + 32'(k))];
  end

  always @(posedge clk) begin
    if (pl_req) begin
      for (int k = 0; k < 4; k++) bmem[8'(pl_addr + 32'(k))] <= pl_data[31-8*k -: 8];
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_a + 32'(k) < 32'd256) bmem[8'(mem_a + 32'(k))] <= mem_wd[31-8*k -: 8];
    end
  end

  function automatic logic [31:0] bmem_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = bmem[8'(a + 32'(k))];
    return w;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (a + 32'(k) < 32'd256) w[31-8*k -: 8] = ref_mem[8'(a + 32'(k))];
    return w;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (a + 32'(k) < 32'd256) ref_mem[8'(a + 32'(k))] = d[31-8*k -: 8];
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Each accepted command is expanded into its externally visible timeline:
  // gnt/err at +1, rvalid at +2, full write at +1, merged write at +2.
  logic [1:0]  e_gnt [4], e_err [4], e_rv [4];
  logic        e_we [4], e_av [4];
  logic [31:0] e_rdata [4], e_wd [4], e_a [4];
  logic [31:0] cur_rd [2];
  logic [31:0] cur_a;
  bit          m_last;
  int          cyc = 0;
  int          free_at = 0;

  task automatic clear_slot(input int s);
    e_gnt[s] = '0; e_err[s] = '0; e_rv[s] = '0; e_we[s] = 1'b0; e_av[s] = 1'b0;
    e_rdata[s] = '0; e_wd[s] = '0; e_a[s] = '0;
  endtask

  always @(negedge clk) begin : model_cmp
    int s, s1, s2;
    bit win, we, oor;
    logic [31:0] a, wd, mg;
    logic [3:0] be;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) clear_slot(i);
      cur_rd[0] = '0; cur_rd[1] = '0; cur_a = '0; m_last = 1'b1; free_at = 0;
      check("rst_flags", {25'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we}, 32'h0);
      check("rst_rdata0", m0_rdata, 32'h0);
      check("rst_rdata1", m1_rdata, 32'h0);
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wd", mem_wd, 32'h0);
      check("rst_state", {30'b0, dbg_state}, 32'h0);
    end else begin
      s = cyc % 4;
      if (e_av[s]) cur_a = e_a[s];
      if (e_rv[s][0]) cur_rd[0] = e_rdata[s];
      if (e_rv[s][1]) cur_rd[1] = e_rdata[s];
      check("gnt", {30'b0, m1_gnt, m0_gnt}, {30'b0, e_gnt[s]});
      check("err", {30'b0, m1_err, m0_err}, {30'b0, e_err[s]});
      check("rvalid", {30'b0, m1_rvalid, m0_rvalid}, {30'b0, e_rv[s]});
      check("rdata0", m0_rdata, cur_rd[0]);
      check("rdata1", m1_rdata, cur_rd[1]);
      check1("mem_we", mem_we, e_we[s]);
      check("mem_a", mem_a, cur_a);
      if (e_we[s]) begin
        check("mem_wd", mem_wd, e_wd[s]);
        ref_wr(cur_a, e_wd[s]);
      end
      clear_slot(s);
      if (cyc >= free_at && (m0_req || m1_req)) begin
        win = (m0_req && m1_req) ? !m_last : m1_req;
        m_last = win;
        we = win ? m1_we : m0_we;
        a  = win ? m1_addr : m0_addr;
        wd = win ? m1_wdata : m0_wdata;
        be = win ? m1_be : m0_be;
        oor = (a > 32'd252);
        s1 = (cyc + 1) % 4;
        s2 = (cyc + 2) % 4;
        e_gnt[s1][win] = 1'b1;
        e_err[s1][win] = oor;
        e_av[s1] = 1'b1;
        e_a[s1] = a;
        free_at = cyc + 2;
        if (!we) begin
          e_rv[s2][win] = 1'b1;
          e_rdata[s2] = oor ? 32'h0 : ref_rd(a);
        end else if (!oor && be == 4'hF) begin
          e_we[s1] = 1'b1;
          e_wd[s1] = wd;
        end else if (!oor && be != 4'h0) begin
          mg = ref_rd(a);
          for (int i = 0; i < 4; i++) if (be[i]) mg[8*i +: 8] = wd[8*i +: 8];
          e_we[s2] = 1'b1;
          e_wd[s2] = mg;
          free_at = cyc + 3;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (p == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = wd; m0_be = be;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be = be;
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] d);
    pl_req = 1'b1; pl_addr = a; pl_data = d;
    ref_wr(a, d);
    step(1);
    pl_req = 1'b0;
  endtask

  // Raises req, waits for gnt (snapshotting the bus then), drops req after it.
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int lat, output logic g_we,
                       output logic g_err, output logic [31:0] g_a, output logic [31:0] g_wd);
    bit got = 0;
    lat = -1; g_we = 1'b0; g_err = 1'b0; g_a = '0; g_wd = '0;
    set_cmd(p, 1'b1, we, a, wd, be);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? m0_gnt : m1_gnt) begin
        got = 1; lat = i; g_we = mem_we; g_a = mem_a; g_wd = mem_wd;
        g_err = (p == 0) ? m0_err : m1_err;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL gnt_timeout port %0d: got no gnt, expected gnt within 20 cycles", p);
    end
    step(1);
    set_cmd(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic read_chk(input int p, input logic [31:0] a, input logic [31:0] exp, input string nm);
    int lat; logic gw, ge; logic [31:0] ga, gwd;
    issue(p, 1'b0, a, 32'h0, 4'h0, lat, gw, ge, ga, gwd);
    @(negedge clk);
    check1({nm, "_rvalid"}, (p == 0) ? m0_rvalid : m1_rvalid, 1'b1);
    check({nm, "_rdata"}, (p == 0) ? m0_rdata : m1_rdata, exp);
    step(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  int lat;
  logic gw, ge;
  logic [31:0] ga, gwd;
  int ord[$];
  logic [31:0] rv0_first, rv1_first;
  bit got0, got1;
  int bad;

  initial begin
    set_cmd(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 64; i++)
      put_word(32'(4 * i), {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} ^ 32'hA5A5_A5A5);
    put_word(32'h10, 32'h1122_3344);
    put_word(32'h30, 32'hAABB_CCDD);
    put_word(32'h40, 32'h5566_7788);
    put_word(32'h50, 32'h0BAD_F00D);
    put_word(32'hFC, 32'hC0FF_EE01);
    rst_n = 1'b1;

    // Plain read: gnt at +1, rvalid at +2, other port quiet.
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, gw, ge, ga, gwd);
    check("t1_gnt_lat", 32'(lat), 32'd1);
    check("t1_mem_a", ga, 32'h10);
    @(negedge clk);
    check1("t1_rvalid", m0_rvalid, 1'b1);
    check("t1_rdata", m0_rdata, 32'h1122_3344);
    check("t1_m1_quiet", {m1_rdata[30:0], m1_rvalid}, 32'h0);
    step(1);

    // Full-word write from port 1, then readback.
    issue(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, lat, gw, ge, ga, gwd);
    check("t2_gnt_lat", 32'(lat), 32'd1);
    check1("t2_we_at_gnt", gw, 1'b1);
    check("t2_mem_a", ga, 32'h20);
    check("t2_mem_wd", gwd, 32'hDEAD_BEEF);
    @(negedge clk);
    check1("t2_single_we", mem_we, 1'b0);
    step(1);
    read_chk(0, 32'h20, 32'hDEAD_BEEF, "t2_rb");

    // Partial write via read-modify-write.
    issue(0, 1'b1, 32'h30, 32'h1122_3344, 4'b0101, lat, gw, ge, ga, gwd);
    check1("t3_no_we_access", gw, 1'b0);
    @(negedge clk);
    check1("t3_we_rmw", mem_we, 1'b1);
    check("t3_merged", mem_wd, 32'hAA22_CC44);
    step(1);
    read_chk(1, 32'h30, 32'hAA22_CC44, "t3_rb");

    // be=0 write leaves memory alone; misaligned full write lands at A..A+3.
    issue(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, lat, gw, ge, ga, gwd);
    check1("t3b_be0_we", gw, 1'b0);
    step(1);
    read_chk(0, 32'h10, 32'h1122_3344, "t3b_be0_rb");
    issue(0, 1'b1, 32'h61, 32'h0102_0304, 4'hF, lat, gw, ge, ga, gwd);
    step(1);
    read_chk(1, 32'h61, 32'h0102_0304, "t3c_misal_rb");

    // Withdrawn request while the arbiter is busy: no access happens.
    set_cmd(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step(1);
    set_cmd(1, 1'b1, 1'b1, 32'h50, 32'hFFFF_FFFF, 4'hF);
    step(1);
    set_cmd(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(3);
    check("t3d_withdrawn", bmem_word(32'h50), 32'h0BAD_F00D);

    // Continuous contention from reset: strict alternation starting with m0.
    do_reset();
    got0 = 0; got1 = 0; rv0_first = '0; rv1_first = '0;
    set_cmd(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_cmd(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m0_gnt) ord.push_back(0);
      if (m1_gnt) ord.push_back(1);
      if (m0_rvalid && !got0) begin got0 = 1; rv0_first = m0_rdata; end
      if (m1_rvalid && !got1) begin got1 = 1; rv1_first = m1_rdata; end
    end
    step(1);
    set_cmd(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(3);
    check("t4_ngnt", 32'(ord.size()), 32'd6);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_order%0d", k), (k < ord.size()) ? 32'(ord[k]) : 32'hFFFF_FFFF, 32'(k % 2));
    check("t4_rv0_data", rv0_first, 32'h1122_3344);
    check("t4_rv1_data", rv1_first, 32'hDEAD_BEEF);

    // Out-of-range accesses on both sides of the boundary.
    issue(1, 1'b0, 32'hFD, 32'h0, 4'h0, lat, gw, ge, ga, gwd);
    check1("t5_err_rd", ge, 1'b1);
    check1("t5_we_rd", gw, 1'b0);
    @(negedge clk);
    check1("t5_rvalid", m1_rvalid, 1'b1);
    check("t5_rdata0", m1_rdata, 32'h0);
    step(1);
    issue(1, 1'b1, 32'hFD, 32'hFFFF_FFFF, 4'hF, lat, gw, ge, ga, gwd);
    check1("t5_err_wr", ge, 1'b1);
    check1("t5_we_wr", gw, 1'b0);
    step(1);
    read_chk(0, 32'hFC, 32'hC0FF_EE01, "t5_edge_rb");
    issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, gw, ge, ga, gwd);
    check1("t5_err_high", ge, 1'b1);
    @(negedge clk);
    check("t5_rdata_high", m0_rdata, 32'h0);
    step(1);

    // Reset during the merge-write cycle aborts the write.
    issue(0, 1'b1, 32'h40, 32'h99AA_BBCC, 4'b1000, lat, gw, ge, ga, gwd);
    rst_n = 1'b0;
    #1;
    check1("t6_we_abort", mem_we, 1'b0);
    step(2);
    check("t6_word_kept", bmem_word(32'h40), 32'h5566_7788);
    rst_n = 1'b1;
    set_cmd(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    set_cmd(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("t6_first_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h1);
    step(1);
    set_cmd(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(4);

    bad = 0;
    for (int i = 0; i < 256; i++) if (bmem[i] !== ref_mem[i]) bad++;
    check("final_mem", 32'(bad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory (combinational read, posedge-clocked 4-byte big-endian write) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Arbitrates round-robin and latches the winning command.
- Performs byte-enabled stores as read-modify-write and returns read data registered.
- Sits between the requesters and the data memory's A/WD/WE/RD pins.

Parameters:
- MEM_BYTES, 256, byte capacity of the attached memory; word accesses with addr > MEM_BYTES-4 are out of range.
- RESET_LAST, 1, last-granted port after reset, so port 0 wins the first tie.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request; held with command until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 store data; [31:24] goes to the lowest address
- m0_be  in  4  port 0 byte enables; be[3] selects wdata[31:24] at addr+0
- m0_gnt  out  1  one-cycle pulse: command accepted
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  32  port 0 read data
- m0_err  out  1  pulses with m0_gnt on an out-of-range access
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable, sampled by memory on posedge clk
- mem_rd  in  32  memory combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last=RESET_LAST.
  - All outputs 0: gnt, rvalid, err, rdata, mem_a, mem_wd, mem_we.
  - Reset mid-access aborts it; no write is issued after reset asserts.
- FSM states: IDLE, ACCESS, RMW_WR.
- IDLE:
  - If any req is high: pick a winner, latch {port, we, addr, wdata, be}, set last=winner, go to ACCESS.
  - Otherwise stay in IDLE with mem_we=0.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port != last wins (strict alternation under contention).
- ACCESS (one cycle):
  - mem_a = latched addr; winner's gnt=1.
  - Out of range (addr > MEM_BYTES-4): mem_we=0, err=1 with gnt. For a read, rvalid pulses next cycle with rdata=0. Go to IDLE.
  - Read: capture mem_rd into winner's rdata at posedge; rvalid=1 in the following cycle. Go to IDLE.
  - Write, be=4'hF: mem_wd=wdata, mem_we=1. Go to IDLE.
  - Write, be=4'h0: no memory write, gnt still pulses. Go to IDLE.
  - Write, other be: register merged = per-byte (be[i] ? wdata byte i : mem_rd byte i). Go to RMW_WR.
- RMW_WR (one cycle): mem_a = latched addr, mem_wd=merged, mem_we=1. Go to IDLE.
- Latency, measured from the first cycle req is high in IDLE with no contention:
  - gnt at +1.
  - Read rvalid at +2.
  - Full-word write committed at end of +1.
  - RMW write committed at end of +2.
- Throughput: at least one IDLE cycle between accesses. A requester that keeps req high is re-arbitrated on that IDLE cycle.
- rdata holds its value until the next read completes for that port. rvalid for port p pulses only for reads issued by p.
- mem_we=1 only in ACCESS (full write) or RMW_WR. mem_a holds its last value in IDLE.
- addr[1:0] is not checked; misaligned addresses pass through unchanged (memory indexes bytes A..A+3).
- A requester dropping req before gnt is legal: request withdrawn, no access.
- Exactly one of m0_gnt/m1_gnt can be high in any cycle.

Test Plan:
- Reset, then m0 read addr 0x10 with memory 0x11223344 at 0x10..0x13 -> m0_gnt at +1, m0_rvalid at +2, m0_rdata=0x11223344, m1 outputs stay 0.
- m1 write addr 0x20, wdata 0xDEADBEEF, be=F -> one mem_we cycle, mem_a=0x20; a subsequent read of 0x20 returns 0xDEADBEEF.
- Word 0xAABBCCDD at 0x30; m0 write wdata 0x11223344, be=4'b0101 -> mem_we only in RMW_WR, mem_wd=0xAA22CC44; readback 0xAA22CC44.
- m0 and m1 both hold read req continuously after reset -> gnt order m0, m1, m0, m1; each rvalid carries its own address's data.
- m1 read addr 0xFD with MEM_BYTES=256 -> m1_err and m1_gnt together, mem_we=0, m1_rvalid next cycle with rdata=0. Same address as a write -> memory unchanged.
- rst_n pulled low during RMW_WR of a be=4'b1000 write -> outputs 0 immediately, target word unchanged, next request served from IDLE with m0 priority.
